// File: rtl/keypad_scanner.sv
// rtl/keypad_scanner.sv - 4x3 matrix keypad column scanner with press/release debounce
module keypad_scanner #(
    parameter int SCAN_DIV       = 256,
    parameter int DEBOUNCE_TICKS = 4
) (
    input  logic       clock,
    input  logic       reset,
    input  logic [3:0] row,
    output logic [2:0] col,
    output logic [3:0] key,
    output logic       key_valid
);

    localparam int PW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int DW = $clog2(DEBOUNCE_TICKS + 1);
    localparam logic [3:0] NOKEY = 4'd10;

    typedef enum logic [1:0] {SCAN, DEBOUNCE, PRESSED, RELEASE} state_t;

    state_t         state, state_n;
    logic [3:0]     row_meta, rs;
    logic [PW-1:0]  pcnt;
    logic [1:0]     ci, ci_n, ci_adv;
    logic [DW-1:0]  dcnt, dcnt_n, dcnt_inc;
    logic [3:0]     cand_row, cand_row_n;
    logic [3:0]     cand_code, cand_code_n;
    logic [3:0]     key_n;
    logic           key_valid_n;
    logic           tick, single, all_high, dcnt_done;
    logic [3:0]     low;

    // Row is the zero bit of a single-low row vector, column is the driven index.
    function automatic logic [3:0] map_code(input logic [3:0] r, input logic [1:0] c);
        logic [3:0] code;
        code = NOKEY;
        case (r)
            4'b1110: code = {2'b00, c} + 4'd1;
            4'b1101: code = {2'b00, c} + 4'd4;
            4'b1011: code = {2'b00, c} + 4'd7;
            4'b0111: begin
                case (c)
                    2'd0:    code = 4'd11;
                    2'd1:    code = 4'd0;
                    default: code = 4'd12;
                endcase
            end
            default: code = NOKEY;
        endcase
        return code;
    endfunction

    assign low       = ~rs;
    assign single    = (low != 4'd0) && ((low & (low - 4'd1)) == 4'd0);
    assign all_high  = (rs == 4'b1111);
    assign tick      = (pcnt == PW'(SCAN_DIV - 1));
    assign ci_adv    = (ci == 2'd2) ? 2'd0 : ci + 2'd1;
    assign dcnt_inc  = dcnt + DW'(1);
    assign dcnt_done = (dcnt_inc == DW'(DEBOUNCE_TICKS));
    assign col       = ~(3'b001 << ci);

    always_comb begin
        state_n     = state;
        ci_n        = ci;
        dcnt_n      = dcnt;
        cand_row_n  = cand_row;
        cand_code_n = cand_code;
        key_n       = key;
        key_valid_n = 1'b0;
        if (tick) begin
            case (state)
                SCAN: begin
                    if (single) begin
                        cand_row_n  = rs;
                        cand_code_n = map_code(rs, ci);
                        if (DEBOUNCE_TICKS == 1) begin
                            key_n       = map_code(rs, ci);
                            key_valid_n = 1'b1;
                            dcnt_n      = '0;
                            state_n     = PRESSED;
                        end else begin
                            dcnt_n  = DW'(1);
                            state_n = DEBOUNCE;
                        end
                    end else begin
                        ci_n = ci_adv;
                    end
                end
                DEBOUNCE: begin
                    if (rs == cand_row) begin
                        if (dcnt_done) begin
                            key_n       = cand_code;
                            key_valid_n = 1'b1;
                            dcnt_n      = '0;
                            state_n     = PRESSED;
                        end else begin
                            dcnt_n = dcnt_inc;
                        end
                    end else begin
                        ci_n    = ci_adv;
                        dcnt_n  = '0;
                        state_n = SCAN;
                    end
                end
                PRESSED: begin
                    // Other keys held alongside the accepted one are ignored until all rows clear.
                    if (all_high) begin
                        if (DEBOUNCE_TICKS == 1) begin
                            key_n   = NOKEY;
                            ci_n    = ci_adv;
                            dcnt_n  = '0;
                            state_n = SCAN;
                        end else begin
                            dcnt_n  = DW'(1);
                            state_n = RELEASE;
                        end
                    end
                end
                RELEASE: begin
                    if (all_high) begin
                        if (dcnt_done) begin
                            key_n   = NOKEY;
                            ci_n    = ci_adv;
                            dcnt_n  = '0;
                            state_n = SCAN;
                        end else begin
                            dcnt_n = dcnt_inc;
                        end
                    end else begin
                        dcnt_n  = '0;
                        state_n = PRESSED;
                    end
                end
                default: begin
                    dcnt_n  = '0;
                    state_n = SCAN;
                end
            endcase
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            row_meta  <= 4'b1111;
            rs        <= 4'b1111;
            pcnt      <= '0;
            state     <= SCAN;
            ci        <= 2'd0;
            dcnt      <= '0;
            cand_row  <= 4'b1111;
            cand_code <= NOKEY;
            key       <= NOKEY;
            key_valid <= 1'b0;
        end else begin
            row_meta  <= row;
            rs        <= row_meta;
            pcnt      <= tick ? '0 : pcnt + PW'(1);
            state     <= state_n;
            ci        <= ci_n;
            dcnt      <= dcnt_n;
            cand_row  <= cand_row_n;
            cand_code <= cand_code_n;
            key       <= key_n;
            key_valid <= key_valid_n;
        end
    end

endmodule

// File: tb/tb_keypad_scanner.sv
// tb/tb_keypad_scanner.sv - randomized keypad scanner bench against a tick-level keypad model
module tb_keypad_scanner;

    localparam int DIV = 4;
    localparam int DT  = 3;

    logic       clock;
    logic       reset;
    logic [3:0] row;
    logic [2:0] col;
    logic [3:0] key;
    logic       key_valid;

    logic [2:0] pressed [4];

    keypad_scanner #(.SCAN_DIV(DIV), .DEBOUNCE_TICKS(DT)) dut (
        .clock     (clock),
        .reset     (reset),
        .row       (row),
        .col       (col),
        .key       (key),
        .key_valid (key_valid)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Physical keypad: a row is pulled low by any pressed key on a driven column.
    always_comb begin
        row = 4'b1111;
        for (int r = 0; r < 4; r++) row[r] = ~|(pressed[r] & ~col);
    end

    int n_cmp = 0;
    int n_err = 0;
    int pulses;
    int accepted [$];

    task automatic check(input string tag, input int got, input int exp);
        n_cmp++;
        if (got != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference model: phases 0 idle-scan, 1 confirming, 2 held, 3 confirming release.
    int keymap [4][3] = '{'{1, 2, 3}, '{4, 5, 6}, '{7, 8, 9}, '{11, 0, 12}};
    int m_cnt, m_ci, m_phase, m_streak, m_key, m_kv, m_code;
    logic [3:0] m_s1, m_s2, m_cand;

    task automatic model_reset();
        m_cnt = 0; m_ci = 0; m_phase = 0; m_streak = 0;
        m_key = 10; m_kv = 0; m_code = 10;
        m_s1 = 4'hf; m_s2 = 4'hf; m_cand = 4'hf;
    endtask

    function automatic logic [3:0] pad_rows(input int c);
        logic [3:0] r4;
        r4 = 4'hf;
        for (int r = 0; r < 4; r++) if (pressed[r][c]) r4[r] = 1'b0;
        return r4;
    endfunction

    task automatic step();
        logic [3:0] rs;
        int rix;
        @(posedge clock);
        if (reset) begin
            model_reset();
        end else begin
            rs   = m_s2;
            m_s2 = m_s1;
            m_s1 = pad_rows(m_ci);
            m_kv = 0;
            if (m_cnt == DIV - 1) begin
                if (m_phase == 0) begin
                    if ($countones(~rs) == 1) begin
                        rix = 0;
                        for (int r = 0; r < 4; r++) if (!rs[r]) rix = r;
                        m_cand = rs; m_code = keymap[rix][m_ci]; m_streak = 1;
                        if (m_streak >= DT) begin m_key = m_code; m_kv = 1; m_phase = 2; end
                        else m_phase = 1;
                    end else m_ci = (m_ci + 1) % 3;
                end else if (m_phase == 1) begin
                    if (rs == m_cand) begin
                        m_streak++;
                        if (m_streak >= DT) begin m_key = m_code; m_kv = 1; m_phase = 2; end
                    end else begin m_ci = (m_ci + 1) % 3; m_phase = 0; end
                end else if (m_phase == 2) begin
                    if (rs == 4'hf) begin
                        m_streak = 1;
                        if (DT == 1) begin m_key = 10; m_ci = (m_ci + 1) % 3; m_phase = 0; end
                        else m_phase = 3;
                    end
                end else begin
                    if (rs == 4'hf) begin
                        m_streak++;
                        if (m_streak >= DT) begin m_key = 10; m_ci = (m_ci + 1) % 3; m_phase = 0; end
                    end else m_phase = 2;
                end
            end
            m_cnt = (m_cnt + 1) % DIV;
        end
        #1;
        check("col", int'(col), 7 & ~(1 << m_ci));
        check("key", int'(key), m_key);
        check("key_valid", int'(key_valid), m_kv);
        if (key_valid) begin
            pulses++;
            accepted.push_back(int'(key));
        end
    endtask

    task automatic steps(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic release_all();
        for (int r = 0; r < 4; r++) pressed[r] = 3'b000;
    endtask

    task automatic press(input int r, input int c);
        pressed[r][c] = 1'b1;
    endtask

    task automatic reset_pulse();
        #2;
        reset = 1'b1;
        #1;
        model_reset();
        check("reset_col", int'(col), 6);
        check("reset_key", int'(key), 10);
        check("reset_kv", int'(key_valid), 0);
        steps(3);
        reset = 1'b0;
    endtask

    task automatic wait_col(input logic [2:0] target);
        int n;
        n = 0;
        while (col != target && n < 20) begin step(); n++; end
        check("wait_col", int'(col), int'(target));
    endtask

    initial begin
        reset = 1'b0;
        release_all();
        pulses = 0;
        model_reset();
        reset_pulse();

        // 1: idle scanning
        pulses = 0;
        steps(40);
        check("s1_pulses", pulses, 0);
        check("s1_key", int'(key), 10);

        // 2: hold '5', then release
        pulses = 0;
        press(1, 1);
        steps(60);
        check("s2_key_held", int'(key), 5);
        check("s2_pulses", pulses, 1);
        release_all();
        steps(60);
        check("s2_key_rel", int'(key), 10);
        check("s2_pulses_rel", pulses, 1);

        // 3: '8' visible for a single tick, then bounces open
        pulses = 0;
        wait_col(3'b110);
        wait_col(3'b101);
        press(2, 1);
        steps(4);
        release_all();
        steps(6);
        check("s3_next_col", int'(col), 3);
        steps(30);
        check("s3_pulses", pulses, 0);
        check("s3_key", int'(key), 10);

        // 4: '1' and '4' together, then '4' released
        pulses = 0;
        press(0, 0);
        press(1, 0);
        steps(60);
        check("s4_ignored", int'(key), 10);
        check("s4_pulses0", pulses, 0);
        pressed[1] = 3'b000;
        steps(60);
        check("s4_key1", int'(key), 1);
        check("s4_pulses1", pulses, 1);
        release_all();
        steps(60);

        // 5: '0', release, '*'
        pulses = 0;
        accepted.delete();
        press(3, 1);
        steps(60);
        check("s5_key0", int'(key), 0);
        release_all();
        steps(60);
        check("s5_key_rel", int'(key), 10);
        press(3, 0);
        steps(60);
        check("s5_key_star", int'(key), 11);
        release_all();
        steps(60);
        check("s5_pulses", pulses, 2);
        if (accepted.size() == 2) begin
            check("s5_first", accepted[0], 0);
            check("s5_second", accepted[1], 11);
        end

        // 6: reset while '9' is held
        pulses = 0;
        press(2, 2);
        steps(60);
        check("s6_key9", int'(key), 9);
        reset_pulse();
        pulses = 0;
        steps(60);
        check("s6_key9_again", int'(key), 9);
        check("s6_pulses", pulses, 1);
        release_all();
        steps(60);

        // Random presses, multi-key chords and short bounces
        for (int it = 0; it < 60; it++) begin
            int mode;
            int dur;
            mode = int'($urandom_range(0, 3));
            release_all();
            if (mode >= 1) press(int'($urandom_range(0, 3)), int'($urandom_range(0, 2)));
            if (mode == 2) press(int'($urandom_range(0, 3)), int'($urandom_range(0, 2)));
            dur = (mode == 3) ? int'($urandom_range(1, 14)) : int'($urandom_range(10, 80));
            steps(dur);
            release_all();
            steps(int'($urandom_range(3, 60)));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
